// File: rtl/udc_pkg.sv
//------------------------------------------------------------------------------
// Module : udc_pkg
// Brief  : Shared mode encodings and bound-clamp helper for the bounded counter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package udc_pkg;

  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  // Width-agnostic clamp: callers zero-extend into 32 bits and truncate back.
  function automatic logic [31:0] clamp(input logic [31:0] v,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/udc_next_value.sv
//------------------------------------------------------------------------------
// Module : udc_next_value
// Brief  : Combinational step arithmetic with bound wrap/saturate and events.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module udc_next_value
  import udc_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int STEP_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0] i_cnt,
  input  logic                  i_up,
  input  logic                  i_down,
  input  logic [STEP_WIDTH-1:0] i_step,
  input  logic [DATA_WIDTH-1:0] i_min,
  input  logic [DATA_WIDTH-1:0] i_max,
  input  logic                  i_wrap,
  input  logic                  i_cfg_err,
  output logic [DATA_WIDTH-1:0] o_next,
  output logic                  o_ovf,
  output logic                  o_unf
);

  localparam int EXT_W = DATA_WIDTH + 1;

  logic [EXT_W-1:0] w_step_ext;
  logic [EXT_W-1:0] w_sum;
  logic [EXT_W-1:0] w_diff;
  logic             w_borrow;
  logic             w_valid;

  // One extra bit keeps the carry/borrow visible instead of wrapping mod 2^N.
  assign w_step_ext = EXT_W'(i_step);
  assign w_sum      = {1'b0, i_cnt} + w_step_ext;
  assign w_diff     = {1'b0, i_cnt} - w_step_ext;
  assign w_borrow   = w_diff[DATA_WIDTH];
  assign w_valid    = (i_up ^ i_down) && (i_step != '0) && !i_cfg_err;

  always_comb begin
    o_next = i_cnt;
    o_ovf  = 1'b0;
    o_unf  = 1'b0;
    if (w_valid && i_up) begin
      if (w_sum > {1'b0, i_max}) begin
        o_ovf  = 1'b1;
        o_next = (i_wrap == MODE_WRAP) ? i_min : i_max;
      end else begin
        o_next = w_sum[DATA_WIDTH-1:0];
      end
    end else if (w_valid && i_down) begin
      if (w_borrow || (w_diff[DATA_WIDTH-1:0] < i_min)) begin
        o_unf  = 1'b1;
        o_next = (i_wrap == MODE_WRAP) ? i_max : i_min;
      end else begin
        o_next = w_diff[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bounded_up_down_counter.sv
//------------------------------------------------------------------------------
// Module : bounded_up_down_counter
// Brief  : Up/down counter with runtime bounds, step, wrap/saturate and events.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bounded_up_down_counter
  import udc_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 5,
  parameter int                    STEP_WIDTH  = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_in,
  input  logic                  i_up,
  input  logic                  i_down,
  input  logic [STEP_WIDTH-1:0] i_step,
  input  logic [DATA_WIDTH-1:0] i_min,
  input  logic [DATA_WIDTH-1:0] i_max,
  input  logic                  i_wrap,
  output logic [DATA_WIDTH-1:0] o_counter,
  output logic                  o_high,
  output logic                  o_low,
  output logic                  o_ovf,
  output logic                  o_unf,
  output logic                  o_cfg_err
);

  logic [DATA_WIDTH-1:0] r_cnt;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_cfg_err;
  logic [DATA_WIDTH-1:0] w_count_next;
  logic                  w_count_ovf;
  logic                  w_count_unf;
  logic [DATA_WIDTH-1:0] w_load_clamped;
  logic [DATA_WIDTH-1:0] w_cnt_d;
  logic                  w_ovf_d;
  logic                  w_unf_d;

  assign w_cfg_err      = (i_min > i_max);
  assign w_load_clamped = DATA_WIDTH'(clamp(32'(i_in), 32'(i_min), 32'(i_max)));

  udc_next_value #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_next (
    .i_cnt     (r_cnt),
    .i_up      (i_up),
    .i_down    (i_down),
    .i_step    (i_step),
    .i_min     (i_min),
    .i_max     (i_max),
    .i_wrap    (i_wrap),
    .i_cfg_err (w_cfg_err),
    .o_next    (w_count_next),
    .o_ovf     (w_count_ovf),
    .o_unf     (w_count_unf)
  );

  // Event flags only come from the count path; every other branch clears them.
  always_comb begin
    w_cnt_d = r_cnt;
    w_ovf_d = 1'b0;
    w_unf_d = 1'b0;
    if (i_clear) begin
      w_cnt_d = i_min;
    end else if (i_load) begin
      w_cnt_d = w_cfg_err ? i_in : w_load_clamped;
    end else if (!w_cfg_err && (r_cnt < i_min)) begin
      w_cnt_d = i_min;
    end else if (!w_cfg_err && (r_cnt > i_max)) begin
      w_cnt_d = i_max;
    end else begin
      w_cnt_d = w_count_next;
      w_ovf_d = w_count_ovf;
      w_unf_d = w_count_unf;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RESET_VALUE;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_ovf <= w_ovf_d;
      r_unf <= w_unf_d;
    end
  end

  assign o_counter = r_cnt;
  assign o_ovf     = r_ovf;
  assign o_unf     = r_unf;
  assign o_cfg_err = w_cfg_err;
  assign o_high    = !w_cfg_err && (r_cnt == i_max);
  assign o_low     = !w_cfg_err && (r_cnt == i_min);

endmodule

`default_nettype wire

// File: tb/tb_bounded_up_down_counter.sv
//------------------------------------------------------------------------------
// Module : tb_bounded_up_down_counter
// Brief  : Directed stimulus against an integer reference model of the counter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bounded_up_down_counter;

  logic       clk;
  logic       rst_n;
  logic       clear, load, up, down, wrap;
  logic [4:0] din, vmin, vmax;
  logic [2:0] step;
  logic [4:0] o_counter;
  logic       o_high, o_low, o_ovf, o_unf, o_cfg_err;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  int m_cnt = 0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  bounded_up_down_counter #(
    .DATA_WIDTH  (5),
    .STEP_WIDTH  (3),
    .RESET_VALUE (5'd0)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clear   (clear),
    .i_load    (load),
    .i_in      (din),
    .i_up      (up),
    .i_down    (down),
    .i_step    (step),
    .i_min     (vmin),
    .i_max     (vmax),
    .i_wrap    (wrap),
    .o_counter (o_counter),
    .o_high    (o_high),
    .o_low     (o_low),
    .o_ovf     (o_ovf),
    .o_unf     (o_unf),
    .o_cfg_err (o_cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model in plain integers: no width tricks, bounds applied directly.
  always @(posedge clk or negedge rst_n) begin
    int lo, hi, n;
    bit err;
    if (!rst_n) begin
      m_cnt <= 0;
      m_ovf <= 1'b0;
      m_unf <= 1'b0;
    end else begin
      lo  = int'(vmin);
      hi  = int'(vmax);
      err = lo > hi;
      m_ovf <= 1'b0;
      m_unf <= 1'b0;
      if (clear) begin
        m_cnt <= lo;
      end else if (load) begin
        if (err)                m_cnt <= int'(din);
        else if (int'(din) < lo) m_cnt <= lo;
        else if (int'(din) > hi) m_cnt <= hi;
        else                    m_cnt <= int'(din);
      end else if (!err && m_cnt < lo) begin
        m_cnt <= lo;
      end else if (!err && m_cnt > hi) begin
        m_cnt <= hi;
      end else if (!err && (up != down) && step != 0) begin
        if (up) begin
          n = m_cnt + int'(step);
          if (n > hi) begin
            m_ovf <= 1'b1;
            m_cnt <= wrap ? lo : hi;
          end else begin
            m_cnt <= n;
          end
        end else begin
          n = m_cnt - int'(step);
          if (n < lo) begin
            m_unf <= 1'b1;
            m_cnt <= wrap ? hi : lo;
          end else begin
            m_cnt <= n;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("cyc_counter", int'(o_counter), m_cnt);
        chk("cyc_ovf",     int'(o_ovf),     int'(m_ovf));
        chk("cyc_unf",     int'(o_unf),     int'(m_unf));
        chk("cyc_cfg_err", int'(o_cfg_err), int'(vmin > vmax));
        chk("cyc_high",    int'(o_high),    int'(!(vmin > vmax) && m_cnt == int'(vmax)));
        chk("cyc_low",     int'(o_low),     int'(!(vmin > vmax) && m_cnt == int'(vmin)));
      end
    end
  end

  // Apply one cycle of controls, then return 2 time units after the edge.
  task automatic cyc(input bit c, input bit l, input int d, input bit u, input bit dn);
    clear = c;
    load  = l;
    din   = 5'(d);
    up    = u;
    down  = dn;
    @(posedge clk);
    #2;
  endtask

  task automatic cfg(input int lo, input int hi, input bit w, input int s);
    vmin = 5'(lo);
    vmax = 5'(hi);
    wrap = w;
    step = 3'(s);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 0; load = 0; up = 0; down = 0; wrap = 0;
    din = '0; vmin = '0; vmax = '0; step = '0;
    @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    #2;
    chk("reset_counter", int'(o_counter), 0);
    chk("reset_ovf", int'(o_ovf), 0);
    chk("reset_unf", int'(o_unf), 0);
    rst_n = 1'b1;

    // 1: saturate at max, repeated overflow pulses
    cfg(0, 20, 0, 3);
    cyc(0, 1, 17, 0, 0);
    chk("t1_load", int'(o_counter), 17);
    cyc(0, 0, 0, 1, 0);
    chk("t1_up1", int'(o_counter), 20);
    chk("t1_up1_ovf", int'(o_ovf), 0);
    cyc(0, 0, 0, 1, 0);
    chk("t1_up2", int'(o_counter), 20);
    chk("t1_up2_ovf", int'(o_ovf), 1);
    cyc(0, 0, 0, 1, 0);
    chk("t1_up3_ovf", int'(o_ovf), 1);
    chk("t1_high", int'(o_high), 1);

    // 2: wrap below min
    cfg(4, 25, 1, 2);
    cyc(0, 1, 6, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t2_dn1", int'(o_counter), 4);
    chk("t2_low", int'(o_low), 1);
    cyc(0, 0, 0, 0, 1);
    chk("t2_dn2", int'(o_counter), 25);
    chk("t2_unf", int'(o_unf), 1);
    cyc(0, 0, 0, 0, 0);
    chk("t2_unf_drop", int'(o_unf), 0);

    // 3: full-range wrap through the carry bit
    cfg(0, 31, 1, 1);
    cyc(0, 1, 31, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t3_wrap", int'(o_counter), 0);
    chk("t3_ovf", int'(o_ovf), 1);
    cyc(0, 0, 0, 1, 0);
    chk("t3_next", int'(o_counter), 1);
    chk("t3_ovf_drop", int'(o_ovf), 0);

    // 4: load clamping and priorities
    cfg(4, 25, 0, 1);
    cyc(0, 1, 30, 0, 0);
    chk("t4_load_hi", int'(o_counter), 25);
    cyc(0, 1, 1, 0, 0);
    chk("t4_load_lo", int'(o_counter), 4);
    cyc(0, 0, 0, 1, 1);
    chk("t4_both", int'(o_counter), 4);
    cyc(1, 1, 20, 0, 0);
    chk("t4_clear_wins", int'(o_counter), 4);

    // 5: bounds moved, then misconfigured bounds
    cyc(0, 1, 20, 0, 0);
    vmax = 5'd15;
    cyc(0, 0, 0, 1, 0);
    chk("t5_clamp", int'(o_counter), 15);
    chk("t5_clamp_ovf", int'(o_ovf), 0);
    cfg(10, 5, 0, 1);
    #1;
    chk("t5_cfg_err", int'(o_cfg_err), 1);
    cyc(0, 0, 0, 1, 0);
    chk("t5_up_ignored", int'(o_counter), 15);
    chk("t5_high", int'(o_high), 0);
    chk("t5_low", int'(o_low), 0);
    cyc(0, 1, 30, 0, 0);
    chk("t5_load_raw", int'(o_counter), 30);

    // 6: async reset in the middle of counting
    cfg(0, 31, 1, 1);
    cyc(1, 0, 0, 0, 0);
    repeat (12) cyc(0, 0, 0, 1, 0);
    chk("t6_pre", int'(o_counter), 12);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async", int'(o_counter), 0);
    chk("t6_async_ovf", int'(o_ovf), 0);
    chk("t6_async_unf", int'(o_unf), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(0, 0, 0, 1, 0);
    chk("t6_resume", int'(o_counter), 1);
    cyc(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
